// File: rtl/soc_arbiter_bb.sv
// Purpose: round-robin arbiter merging MASTERS Blackbone master ports onto one slave port.
// Latency: grant and slave request are combinational (0 cycles); read data returns 1 cycle later.
// Backpressure: every requester that is not granted sees m_stall_o and holds its request.
//
// Ports:
//   clk_i, rst_i               clock and synchronous active-low reset
//   m_addr_i/m_din_i/m_we_i    per-master request fields (packed [MASTERS][W])
//   m_en_i                     per-master transfer request
//   m_dout_o/m_valid_o         per-master read return (zero on lanes not returning)
//   m_stall_o                  per-master "not accepted this cycle"
//   s_addr_o/s_din_o/s_we_o    granted master's fields (master 0's when idle)
//   s_en_o                     transfer issued to the slave
//   s_dout_i                   slave read data, one cycle after a read is issued
module soc_arbiter_bb #(
    parameter int MASTERS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [MASTERS-1:0][ADDR_WIDTH-1:0]    m_addr_i,
    input  logic [MASTERS-1:0][DATA_WIDTH-1:0]    m_din_i,
    input  logic [MASTERS-1:0]                    m_en_i,
    input  logic [MASTERS-1:0]                    m_we_i,
    output logic [MASTERS-1:0][DATA_WIDTH-1:0]    m_dout_o,
    output logic [MASTERS-1:0]                    m_valid_o,
    output logic [MASTERS-1:0]                    m_stall_o,
    output logic [ADDR_WIDTH-1:0]                 s_addr_o,
    output logic [DATA_WIDTH-1:0]                 s_din_o,
    output logic                                  s_we_o,
    output logic                                  s_en_o,
    input  logic [DATA_WIDTH-1:0]                 s_dout_i
);

    localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    // One extra bit so the counter can hold the limit value itself.
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);

    // Arbitration state
    logic [IW-1:0]      owner;
    logic               owner_vld;
    logic [IW-1:0]      last;
    logic [BW-1:0]      burst_cnt;
    // Pending read return
    logic               rd_vld;
    logic [IW-1:0]      rd_idx;

    // Combinational grant
    logic [MASTERS-1:0] owner_oh;
    logic               others_req;
    logic               limit_hit;
    logic               keep;
    logic [IW-1:0]      rr_sel;
    logic               any_req;
    logic               gnt_vld;
    logic [IW-1:0]      gnt_idx;
    logic [MASTERS-1:0] gnt_oh;
    logic [IW-1:0]      sel;
    logic               restart;

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    assign others_req = |(m_en_i & ~owner_oh);
    assign limit_hit  = (MAX_BURST != 0) && (burst_cnt >= BURST_LIM);

    // The owner keeps the bus while it still requests, unless it has used up
    // its burst allowance and somebody else is waiting.
    assign keep = owner_vld && m_en_i[owner] &&
                  ((MAX_BURST == 0) || (burst_cnt < BURST_LIM) || !others_req);

    // Round-robin scan starting just after the last granted master; the last
    // granted master itself is considered last of all.
    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        found  = 1'b0;
        cand   = '0;
        rr_sel = '0;
        for (int d = 1; d <= MASTERS; d++) begin
            cand = IW'((int'(last) + d) % MASTERS);
            if (!found && m_en_i[cand]) begin
                found  = 1'b1;
                rr_sel = cand;
            end
        end
    end

    assign any_req = |m_en_i;
    // No grant is ever issued while reset is held.
    assign gnt_vld = any_req && rst_i;
    assign gnt_idx = keep ? owner : rr_sel;

    always_comb begin
        gnt_oh = '0;
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    // Master 0 drives the slave fields whenever nobody is granted.
    assign sel = gnt_vld ? gnt_idx : '0;

    assign s_en_o    = gnt_vld;
    assign s_addr_o  = m_addr_i[sel];
    assign s_din_o   = m_din_i[sel];
    assign s_we_o    = rst_i && m_we_i[sel];
    assign m_stall_o = m_en_i & ~gnt_oh;

    // Read return is steered by the captured index, never by the current grant,
    // so a new grant to another master can overlap the return.
    always_comb begin
        m_valid_o = '0;
        m_dout_o  = '0;
        if (rst_i && rd_vld) begin
            m_valid_o[rd_idx] = 1'b1;
            m_dout_o[rd_idx]  = s_dout_i;
        end
    end

    // A fresh run starts on an owner change, after an idle cycle, or when the
    // allowance was exhausted (owner kept only because nobody else asked).
    assign restart = !owner_vld || (gnt_idx != owner) || limit_hit;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            owner     <= '0;
            owner_vld <= 1'b0;
            last      <= IW'(MASTERS - 1);
            burst_cnt <= '0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
        end else begin
            rd_vld <= gnt_vld && !m_we_i[gnt_idx];
            if (gnt_vld) begin
                owner     <= gnt_idx;
                owner_vld <= 1'b1;
                last      <= gnt_idx;
                rd_idx    <= gnt_idx;
                burst_cnt <= restart ? BW'(1) : burst_cnt + BW'(1);
            end else begin
                owner_vld <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_soc_arbiter_bb.sv
// Purpose: self-checking bench for soc_arbiter_bb; four instances with
// MASTERS=3 and MAX_BURST = 1, 4, 2, 0 share one stimulus and each is
// compared every cycle against a reference model, plus directed expectations.
module tb_soc_arbiter_bb;

    localparam int NI = 4;
    localparam int NM = 3;

    function automatic int mb_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NM-1:0][31:0]  addr;
    logic [NM-1:0][31:0]  din;
    logic [NM-1:0]        en;
    logic [NM-1:0]        we;
    logic [31:0]          sdout;

    logic [NM-1:0][31:0]  o_mdout  [NI];
    logic [NM-1:0]        o_mvalid [NI];
    logic [NM-1:0]        o_mstall [NI];
    logic [31:0]          o_saddr  [NI];
    logic [31:0]          o_sdin   [NI];
    logic                 o_swe    [NI];
    logic                 o_sen    [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        soc_arbiter_bb #(
            .MASTERS    (NM),
            .DATA_WIDTH (32),
            .ADDR_WIDTH (32),
            .MAX_BURST  (mb_of(k))
        ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .m_addr_i  (addr),
            .m_din_i   (din),
            .m_en_i    (en),
            .m_we_i    (we),
            .m_dout_o  (o_mdout[k]),
            .m_valid_o (o_mvalid[k]),
            .m_stall_o (o_mstall[k]),
            .s_addr_o  (o_saddr[k]),
            .s_din_o   (o_sdin[k]),
            .s_we_o    (o_swe[k]),
            .s_en_o    (o_sen[k]),
            .s_dout_i  (sdout)
        );
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: who holds the bus, how long its current run is, who
    // was granted most recently, and which master awaits read data.
    int holder   [NI];
    bit holding  [NI];
    int run_len  [NI];
    int recent   [NI];
    bit rd_pend  [NI];
    int rd_who   [NI];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int model_grant(input int k);
        bit contender;
        contender = 1'b0;
        for (int i = 0; i < NM; i++)
            if (en[i] && i != holder[k]) contender = 1'b1;
        if (holding[k] && en[holder[k]] &&
            (mb_of(k) == 0 || run_len[k] < mb_of(k) || !contender))
            return holder[k];
        for (int d = 1; d <= NM; d++)
            if (en[(recent[k] + d) % NM]) return (recent[k] + d) % NM;
        return -1;
    endfunction

    task automatic model_reset(input int k);
        holding[k] = 1'b0;
        holder[k]  = 0;
        run_len[k] = 0;
        recent[k]  = NM - 1;
        rd_pend[k] = 1'b0;
        rd_who[k]  = 0;
    endtask

    task automatic model_update();
        for (int k = 0; k < NI; k++) begin
            int g;
            if (!rst) begin
                model_reset(k);
            end else begin
                g = model_grant(k);
                rd_pend[k] = (g >= 0) && !we[g];
                if (g >= 0) begin
                    rd_who[k] = g;
                    if (holding[k] && g == holder[k] &&
                        !(mb_of(k) != 0 && run_len[k] >= mb_of(k)))
                        run_len[k] = run_len[k] + 1;
                    else
                        run_len[k] = 1;
                    holder[k]  = g;
                    holding[k] = 1'b1;
                    recent[k]  = g;
                end else begin
                    holding[k] = 1'b0;
                    run_len[k] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            int                  g;
            int                  s;
            logic                x_en;
            logic                x_we;
            logic [NM-1:0]       x_stall;
            logic [NM-1:0]       x_valid;
            logic [NM-1:0][31:0] x_dout;
            g       = rst ? model_grant(k) : -1;
            s       = (g >= 0) ? g : 0;
            x_en    = (g >= 0);
            x_we    = rst && we[s];
            x_stall = en;
            if (g >= 0) x_stall[g] = 1'b0;
            x_valid = '0;
            x_dout  = '0;
            if (rst && rd_pend[k]) begin
                x_valid[rd_who[k]] = 1'b1;
                x_dout[rd_who[k]]  = sdout;
            end
            chk($sformatf("u%0d s_en", k),    o_sen[k],    x_en);
            chk($sformatf("u%0d s_we", k),    o_swe[k],    x_we);
            chk($sformatf("u%0d s_addr", k),  o_saddr[k],  addr[s]);
            chk($sformatf("u%0d s_din", k),   o_sdin[k],   din[s]);
            chk($sformatf("u%0d m_stall", k), o_mstall[k], x_stall);
            chk($sformatf("u%0d m_valid", k), o_mvalid[k], x_valid);
            chk($sformatf("u%0d m_dout", k),  o_mdout[k],  x_dout);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] std_addr(input int i);
        return 32'h1000 + 32'(i) * 32'h10;
    endfunction

    task automatic set_std();
        for (int i = 0; i < NM; i++) begin
            addr[i] = std_addr(i);
            din[i]  = 32'hA000_0000 + 32'(i);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        en  = '0;
        sample();
        advance();
        rst = 1'b1;
    endtask

    initial begin
        logic [NM-1:0] xs;
        logic [NM-1:0][31:0] rd;
        for (int k = 0; k < NI; k++) model_reset(k);
        rst   = 1'b0;
        en    = '0;
        we    = '0;
        sdout = '0;
        set_std();

        // Reset held with two requesters: everything forced quiet.
        en = 3'b011;
        we = 3'b111;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("rst s_en", o_sen[1], 1'b0);
            chk("rst m_stall", o_mstall[1], 3'b011);
            chk("rst m_valid", o_mvalid[1], 3'b000);
            advance();
        end
        rst = 1'b1;
        sample();
        chk("first grant addr", o_saddr[1], std_addr(0));
        chk("first grant stall", o_mstall[1], 3'b010);
        advance();
        en = '0;
        sample();
        advance();

        // Single read from master 1.
        en      = 3'b010;
        we      = 3'b000;
        addr[1] = 32'h100;
        sample();
        chk("read s_en", o_sen[0], 1'b1);
        chk("read s_addr", o_saddr[0], 32'h100);
        advance();
        en    = '0;
        sdout = 32'hDEADBEEF;
        sample();
        rd = o_mdout[0];
        chk("read m_valid", o_mvalid[0], 3'b010);
        chk("read dout1", rd[1], 32'hDEADBEEF);
        chk("read dout0", rd[0], 32'h0);
        advance();

        // Round-robin with MAX_BURST=1 (instance 0).
        set_std();
        reset_pulse();
        en = 3'b111;
        we = 3'b111;
        for (int c = 0; c < 6; c++) begin
            xs = 3'b111;
            xs[c % NM] = 1'b0;
            sample();
            chk("rr addr", o_saddr[0], std_addr(c % NM));
            chk("rr stall", o_mstall[0], xs);
            advance();
        end

        // Burst limit with MAX_BURST=4 (instance 1).
        reset_pulse();
        for (int c = 0; c < 10; c++) begin
            en = 3'b001;
            en[1] = (c >= 1 && c <= 4);
            sample();
            chk("burst addr", o_saddr[1], std_addr((c == 4) ? 1 : 0));
            advance();
        end

        // Limit reached with no contender, MAX_BURST=2 (instance 2).
        reset_pulse();
        en = 3'b001;
        for (int c = 0; c < 6; c++) begin
            sample();
            chk("solo s_en", o_sen[2], 1'b1);
            chk("solo stall", o_mstall[2], 3'b000);
            advance();
        end

        // Reset arriving while a read is in flight.
        reset_pulse();
        en = 3'b001;
        we = 3'b000;
        sample();
        chk("midrd s_en", o_sen[3], 1'b1);
        advance();
        rst   = 1'b0;
        en    = '0;
        sdout = 32'h1234_5678;
        sample();
        chk("midrd valid in rst", o_mvalid[3], 3'b000);
        advance();
        rst = 1'b1;
        sample();
        chk("midrd valid after", o_mvalid[3], 3'b000);
        advance();
        en = 3'b111;
        we = 3'b111;
        sample();
        chk("midrd last ptr", o_saddr[3], std_addr(0));
        advance();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 49) != 0);
            en    = NM'($urandom);
            we    = NM'($urandom);
            sdout = $urandom;
            for (int i = 0; i < NM; i++) begin
                addr[i] = $urandom;
                din[i]  = $urandom;
            end
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_arbiter_bb.md
# soc_arbiter_bb

Round-robin arbiter for the Blackbone bus: merges `MASTERS` Blackbone master ports onto one Blackbone slave port. It is the many-to-one counterpart of the one-to-many address decoder and sits between multiple bus initiators (CPU data port, DMA, debug) and a shared slave or decoder input. It grants one master per cycle, holds the grant across back-to-back bursts up to a fairness limit, stalls the losers, and routes one-cycle-latency read data back to the issuing master.

## Interface
- `MASTERS`, 2: number of master ports, 2..8.
- `DATA_WIDTH`, 32: data width in bits, a multiple of 8.
- `ADDR_WIDTH`, 32: address width in bits.
- `MAX_BURST`, 16: maximum consecutive granted cycles for one owner while others wait; 0 means unlimited.

Ports:
- `clk_i` in 1: clock; all state on the rising edge.
- `rst_i` in 1: synchronous, active-low reset.
- `m_addr_i` in [MASTERS][ADDR_WIDTH]: per-master address.
- `m_din_i` in [MASTERS][DATA_WIDTH]: per-master write data.
- `m_en_i` in [MASTERS]: per-master transfer request.
- `m_we_i` in [MASTERS]: per-master write enable.
- `m_dout_o` out [MASTERS][DATA_WIDTH]: per-master read data; zero unless `m_valid_o[i]` is high.
- `m_valid_o` out [MASTERS]: read data valid, one cycle per completed read.
- `m_stall_o` out [MASTERS]: request not accepted this cycle; the master holds addr/din/we/en unchanged.
- `s_addr_o`, `s_din_o`, `s_we_o` out [ADDR_WIDTH]/[DATA_WIDTH]/1: granted master's signals; index 0's when idle.
- `s_en_o` out 1: transfer issued to the slave.
- `s_dout_i` in [DATA_WIDTH]: slave read data, valid one cycle after a read `s_en_o`.

## Operation
- State registers:
  - `owner` (index) and `owner_vld`.
  - `last`: index of the most recent grant; round-robin pointer.
  - `burst_cnt`: width clog2(MAX_BURST)+1.
  - `rd_vld` and `rd_idx`: pending read return.
- Grant is combinational in the same cycle, so there is zero added latency when the bus is idle:
  - Keep: if `owner_vld & m_en_i[owner]` and (`MAX_BURST==0` or `burst_cnt < MAX_BURST` or no other `m_en_i` set), grant `owner`.
  - Else: grant the first set `m_en_i[j]` scanning j = last+1, last+2, … modulo MASTERS.
  - No request: no grant, `s_en_o = 0`.
- Outputs per cycle:
  - `s_en_o = |m_en_i`.
  - `m_stall_o[i] = m_en_i[i] & ~grant[i]`.
- Register update on a granted cycle:
  - `owner <= g`, `owner_vld <= 1`, `last <= g`.
  - `burst_cnt <= 1` if g ≠ previous owner or the limit was reached, else `burst_cnt + 1`.
- Register update on a cycle with no request: `owner_vld <= 0`, `burst_cnt <= 0`.
- Read return: a granted cycle with `s_we_o = 0` sets `rd_vld <= 1`, `rd_idx <= g`. The next cycle drives `m_dout_o[rd_idx] = s_dout_i` and `m_valid_o[rd_idx] = 1`; all other lanes are 0.
- Writes produce no `m_valid_o`.
- Reset (`rst_i` = 0 at an edge): `owner_vld=0`, `last=MASTERS-1` (master 0 has first priority), `burst_cnt=0`, `rd_vld=0`.
- While `rst_i` is low, outputs are forced:
  - `s_en_o=0`, `s_we_o=0`.
  - `m_stall_o = m_en_i`.
  - `m_valid_o=0`, `m_dout_o=0`.
  - `s_addr_o`/`s_din_o` follow master 0.
- A read in flight when reset asserts is dropped: no `m_valid_o` afterwards.

## Timing
- Request to slave: 0 cycles when the request is granted.
- Read data to master: 1 cycle after the granted cycle.
- Back-to-back transfers: one per cycle, with no bubble on owner change.
- Fairness with `MAX_BURST` = N > 0: a waiting master is granted within N×(MASTERS−1) cycles.
- Simultaneous events:
  - Burst limit reached with no other request: owner continues; `burst_cnt` restarts at 1.
  - Owner drops `m_en_i` while others request: the switch happens in the same cycle, using round-robin from `last`.
- Read return and a new grant to a different master can occur in the same cycle; return routing uses `rd_idx`, never the current grant.

## Test plan
- **Reset:** hold `rst_i`=0 with `m_en_i`=2'b11 for 3 cycles. Expect `s_en_o`=0, `m_stall_o`=2'b11, `m_valid_o`=0. Release reset; the first grant goes to master 0.
- **Single read:** master 1 reads addr 0x100; slave returns 0xDEADBEEF the next cycle. Expect `s_en_o`=1, `s_addr_o`=0x100 in cycle 0. Expect `m_valid_o`=2'b10 and `m_dout_o[1]`=0xDEADBEEF in cycle 1; `m_dout_o[0]`=0.
- **Round-robin:** MASTERS=3, all request single-cycle writes continuously, MAX_BURST=1. Expect grant order 0,1,2,0,1,2; each loser is stalled on its waiting cycles.
- **Burst limit:** MAX_BURST=4, master 0 requests for 10 cycles, master 1 requests from cycle 1.
  - Master 0 is granted in cycles 0–3, master 1 in cycle 4, master 0 in cycle 5 onward.
  - Master 1 holds its request throughout.
- **Limit, no contender:** MAX_BURST=2, only master 0 requests for 6 cycles. Expect 6 consecutive grants with no stall.
- **Reset mid-read:** master 0 read granted in cycle 0, `rst_i`=0 at the cycle-1 edge. Expect `m_valid_o`=0 in cycle 1 and after; after release, `last` is MASTERS−1.
